ham_encoder_stream: RTL and testbench

//  Streaming Hamming(7,4) encoder: the stage directly upstream of ham_decoder.

---
 rtl/ham_encoder_stream.sv | 116 +++++++++++
 tb/tb_ham_encoder_stream.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ham_encoder_stream.sv
// Streaming Hamming(7,4) encoder with optional per-word single-bit error injection.
// Codewords are buffered in a small FIFO and presented from its registered head.
//
//  fill state   | meaning
//  FILL_EMPTY   | count == 0, nothing to deliver
//  FILL_PARTIAL | 0 < count < DEPTH, accept and deliver both possible
//  FILL_FULL    | count == DEPTH, only deliver possible

module ham_encoder_stream #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic [2:0]       inj_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_code,
    output logic             out_injected,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] inj_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_PARTIAL = 2'd1,
        FILL_FULL    = 2'd2
    } fill_state_t;

    fill_state_t     fill_state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [6:0]      code_mem [DEPTH];
    logic            inj_mem  [DEPTH];
    logic [6:0]      enc_code;
    logic [6:0]      inj_mask;
    logic            accept;
    logic            deliver;

    // Positions 1,2,4 carry parity; 3,5,6,7 carry d0..d3 (bit p-1 holds position p).
    function automatic logic [6:0] hamming_encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    always_comb begin
        enc_code = hamming_encode(in_data);
        inj_mask = 7'd0;
        if (inj_pos != 3'd0) begin
            inj_mask = 7'd1 << (inj_pos - 3'd1);
        end
    end

    always_comb begin
        fill_state = FILL_PARTIAL;
        if (count == CW'(0)) begin
            fill_state = FILL_EMPTY;
        end else if (count == CW'(DEPTH)) begin
            fill_state = FILL_FULL;
        end
    end

    // No pass-through when full: in_ready depends only on stored occupancy.
    assign in_ready     = !rst && (fill_state != FILL_FULL);
    assign out_valid    = (fill_state != FILL_EMPTY);
    assign accept       = in_valid && in_ready;
    assign deliver      = out_valid && out_ready;
    assign out_code     = code_mem[rd_ptr];
    assign out_injected = inj_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            word_cnt <= '0;
            inj_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                code_mem[i] <= 7'd0;
                inj_mem[i]  <= 1'b0;
            end
        end else begin
            if (accept) begin
                code_mem[wr_ptr] <= enc_code ^ inj_mask;
                inj_mem[wr_ptr]  <= (inj_pos != 3'd0);
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (deliver) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, deliver})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Statistics saturate rather than wrap.
            if (deliver && (word_cnt != {CNT_W{1'b1}})) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (deliver && out_injected && (inj_cnt != {CNT_W{1'b1}})) begin
                inj_cnt <= inj_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ham_encoder_stream.sv
// Bench for ham_encoder_stream: directed scenarios then randomized traffic,
// checked against a queue model that builds codewords from the parity-coverage rule.

module tb_ham_encoder_stream;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic [2:0]       inj_pos;
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       out_code;
    logic             out_injected;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] inj_cnt;

    ham_encoder_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .inj_pos(inj_pos),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_injected(out_injected), .word_cnt(word_cnt), .inj_cnt(inj_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic [2:0] pos;
    } entry_t;

    entry_t q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     exp_words = 0;
    int     exp_inj = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Parity bit at position b covers every other position whose index has bit b set.
    function automatic logic [6:0] ref_encode(input logic [3:0] d, input logic [2:0] pos);
        logic [6:0] c;
        int dpos[4] = '{3, 5, 6, 7};
        int ppos[3] = '{1, 2, 4};
        logic par;
        c = 7'd0;
        for (int i = 0; i < 4; i++) c[dpos[i]-1] = d[i];
        for (int j = 0; j < 3; j++) begin
            par = 1'b0;
            for (int p = 1; p <= 7; p++)
                if (((p & ppos[j]) != 0) && (p != ppos[j])) par ^= c[p-1];
            c[ppos[j]-1] = par;
        end
        if (pos != 3'd0) c[pos-1] = ~c[pos-1];
        return c;
    endfunction

    function automatic int syndrome(input logic [6:0] c);
        int s = 0;
        for (int p = 1; p <= 7; p++) if (c[p-1]) s ^= p;
        return s;
    endfunction

    task automatic check_outputs();
        logic [6:0] fixed;
        int s;
        chk_eq("in_ready", in_ready, (!rst && q.size() < DEPTH));
        chk_eq("out_valid", out_valid, (q.size() != 0));
        chk_eq("word_cnt", word_cnt, exp_words);
        chk_eq("inj_cnt", inj_cnt, exp_inj);
        if (q.size() != 0) begin
            chk_eq("out_code", out_code, ref_encode(q[0].data, q[0].pos));
            chk_eq("out_injected", out_injected, (q[0].pos != 3'd0));
            s = syndrome(out_code);
            chk_eq("syndrome", s, q[0].pos);
            fixed = out_code;
            if (s != 0) fixed[s-1] = ~fixed[s-1];
            chk_eq("decoded_data", {fixed[6], fixed[5], fixed[4], fixed[2]}, q[0].data);
        end else if (rst) begin
            chk_eq("rst_out_code", out_code, 7'd0);
            chk_eq("rst_out_injected", out_injected, 1'b0);
        end
    endtask

    // Drive one cycle's inputs, advance the model across the edge, check after it.
    task automatic cycle(input logic r, input logic iv, input logic [3:0] d,
                         input logic [2:0] p, input logic ordy);
        logic acc, del;
        entry_t e;
        rst = r; in_valid = iv; in_data = d; inj_pos = p; out_ready = ordy;
        #1;
        chk_eq("in_ready_pre", in_ready, (!r && q.size() < DEPTH));
        if (r) begin
            q.delete();
            exp_words = 0;
            exp_inj = 0;
        end else begin
            acc = iv && (q.size() < DEPTH);
            del = ordy && (q.size() != 0);
            if (del) begin
                if (exp_words < 65535) exp_words++;
                if (q[0].pos != 3'd0 && exp_inj < 65535) exp_inj++;
                void'(q.pop_front());
            end
            if (acc) begin
                e.data = d;
                e.pos = p;
                q.push_back(e);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; inj_pos = 3'd0; out_ready = 1'b0;
        cycle(1, 0, 4'd0, 3'd0, 0);
        cycle(1, 1, 4'd5, 3'd0, 1);

        // Single word with downstream ready.
        cycle(0, 1, 4'b1011, 3'd0, 1);
        chk_eq("tc1_code", out_code, 7'b1010101);
        chk_eq("tc1_inj", out_injected, 1'b0);
        cycle(0, 1, 4'b0000, 3'd0, 1);
        chk_eq("tc1_word_cnt", word_cnt, 1);
        chk_eq("tc2_zero", out_code, 7'b0000000);
        cycle(0, 1, 4'b1111, 3'd0, 1);
        chk_eq("tc2_ones", out_code, 7'b1111111);
        cycle(0, 1, 4'b0001, 3'd0, 1);
        chk_eq("tc2_0001", out_code, 7'b0000111);
        cycle(0, 1, 4'b1011, 3'd7, 1);
        chk_eq("tc3_code", out_code, 7'b0010101);
        chk_eq("tc3_inj", out_injected, 1'b1);
        cycle(0, 0, 4'd0, 3'd0, 1);
        chk_eq("tc3_inj_cnt", inj_cnt, 1);

        // Backpressure: third word held until space frees up.
        cycle(0, 1, 4'h3, 3'd0, 0);
        cycle(0, 1, 4'h6, 3'd2, 0);
        chk_eq("tc4_full_ready", in_ready, 1'b0);
        cycle(0, 1, 4'h9, 3'd0, 0);
        cycle(0, 1, 4'h9, 3'd0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 4'd0, 3'd0, 1);

        // Streaming at full rate.
        for (int i = 0; i < 8; i++) cycle(0, 1, 4'(i * 3), 3'(i % 8), 1);
        cycle(0, 0, 4'd0, 3'd0, 1);

        // Reset with the FIFO full.
        cycle(0, 1, 4'hA, 3'd1, 0);
        cycle(0, 1, 4'hC, 3'd0, 0);
        cycle(1, 1, 4'hE, 3'd0, 1);
        chk_eq("tc6_valid", out_valid, 1'b0);
        cycle(0, 0, 4'd0, 3'd0, 1);
        chk_eq("tc6_ready", in_ready, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  4'($urandom), 3'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
